// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - single-beat bus transaction sequencer (optional watchdog: BUS_TIMEOUT_EN)
module bus_xfer_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          m_get,
    input  logic [3:0]          m_req,
    input  logic [3:0]          m_we,
    input  logic [4*ADDR_W-1:0] m_addr,
    input  logic [4*DATA_W-1:0] m_wdata,
    output logic [3:0]          m_ack,
    output logic [3:0]          m_err,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                busy,
    output logic [3:0]          s_cs,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic [4*DATA_W-1:0] s_rdata,
    input  logic [3:0]          s_ack
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        slave_q, slave_d;
    logic [3:0]        s_cs_q, s_cs_d;
    logic              s_we_q, s_we_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [3:0]        m_ack_q, m_ack_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

    logic [ADDR_W-1:0] addr_arr  [4];
    logic [DATA_W-1:0] wdata_arr [4];
    logic [DATA_W-1:0] rdata_arr [4];
    logic [1:0]        sel;
    logic              ack_hit;
    logic              timeout_hit;
    logic [3:0]        idx_onehot;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = m_wdata[g*DATA_W +: DATA_W];
        assign rdata_arr[g] = s_rdata[g*DATA_W +: DATA_W];
    end

    assign ack_hit    = s_ack[slave_q];
    assign idx_onehot = 4'b0001 << idx_q;

    // Lowest granted master wins when the arbiter hands over more than one grant bit
    always_comb begin
        casez (m_get)
            4'b???1: sel = 2'd0;
            4'b??10: sel = 2'd1;
            4'b?100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       m_err_q, m_err_d;

    // Timeout fires on the TIMEOUT_CYC-th ACCESS cycle only if the slave is silent in it
    assign timeout_hit = (state_q == ST_ACCESS) && !ack_hit &&
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter rests at zero in IDLE, so every ACCESS entry starts from a clean count
    always_comb begin
        cnt_d   = cnt_q;
        m_err_d = 4'b0000;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_ACCESS && !ack_hit && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            m_err_d = idx_onehot;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            m_err_q <= 4'b0000;
        end else begin
            cnt_q   <= cnt_d;
            m_err_q <= m_err_d;
        end
    end

    assign m_err = m_err_q;
`else
    assign timeout_hit = 1'b0;
    assign m_err       = 4'b0000;
`endif

    // Sequencer: latch the granted request, hold the slave strobe, emit one response beat
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        slave_d   = slave_q;
        s_cs_d    = s_cs_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_d   = 4'b0000;
        m_rdata_d = m_rdata_q;
        case (state_q)
            ST_IDLE: begin
                s_cs_d = 4'b0000;
                if (m_get != 4'b0000 && m_req[sel]) begin
                    idx_d     = sel;
                    slave_d   = addr_arr[sel][ADDR_W-1 -: 2];
                    s_cs_d    = 4'b0001 << addr_arr[sel][ADDR_W-1 -: 2];
                    s_we_d    = m_we[sel];
                    s_addr_d  = addr_arr[sel];
                    s_wdata_d = wdata_arr[sel];
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ack_hit) begin
                    s_cs_d    = 4'b0000;
                    m_ack_d   = idx_onehot;
                    m_rdata_d = rdata_arr[slave_q];
                    state_d   = ST_RESP;
                end else if (timeout_hit) begin
                    s_cs_d    = 4'b0000;
                    m_rdata_d = '0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                s_cs_d  = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            slave_q   <= 2'd0;
            s_cs_q    <= 4'b0000;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= 4'b0000;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            slave_q   <= slave_d;
            s_cs_q    <= s_cs_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ack_q   <= m_ack_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign s_cs    = s_cs_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign m_ack   = m_ack_q;
    assign m_rdata = m_rdata_q;

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Transaction sequencer between the 4-master bus arbiter and the slave side of the shared system bus. It takes the one-hot grant from the arbiter and latches the granted master's single-beat read/write request. It decodes the target slave from the top address bits, drives the slave strobe until the slave acknowledges, and returns a one-cycle acknowledge, with read data, to the originating master. An optional watchdog converts a hung slave access into an error response.

## Interface
- ADDR_W, 32, address width; slave index = addr[ADDR_W-1:ADDR_W-2]
- DATA_W, 32, data width
- TIMEOUT_CYC, 16, ACCESS cycles without ack before error (used only with watchdog)
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- m_get  in  4  one-hot grant from arbiter (bit i = master i)
- m_req  in  4  per-master request, held until m_ack/m_err
- m_we  in  4  per-master write enable (1 = write)
- m_addr  in  4*ADDR_W  packed master addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  4*DATA_W  packed master write data
- m_ack  out  4  one-cycle completion pulse to the originating master
- m_err  out  4  one-cycle error pulse (timeout)
- m_rdata  out  DATA_W  read data, valid in the m_ack cycle
- busy  out  1  high in any state other than IDLE
- s_cs  out  4  one-hot slave select
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  4*DATA_W  packed slave read data
- s_ack  in  4  per-slave acknowledge

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, grant-to-master selection:
  - sel = lowest set bit of m_get.
  - If m_get is nonzero and m_req[sel] = 1: latch idx = sel, we, addr and wdata of master sel; slave = addr[ADDR_W-1:ADDR_W-2]; go to ACCESS.
  - Otherwise stay in IDLE. A request without a grant is ignored.
- ACCESS:
  - s_cs[slave] = 1. s_we, s_addr and s_wdata are driven from the latched values, stable for the whole state.
  - On s_ack[slave] = 1: capture s_rdata[slave] (captured for writes too) and go to RESP.
  - s_ack bits of other slaves are ignored.
- RESP:
  - m_ack[idx] = 1 and m_rdata = captured data for exactly one cycle; s_cs = 0.
  - Next state is always IDLE.
- The latched idx is authoritative:
  - A grant change or request drop during ACCESS/RESP does not abort the transaction.
  - The response still goes to idx.
- m_rdata holds its last value outside RESP.
- Only one transaction is in flight at a time; there is no pipelining.

## Timing
- Reset values:
  - state = IDLE.
  - m_ack, m_err, s_cs = 0; s_we = 0; s_addr, s_wdata, m_rdata = 0; busy = 0.
  - Timeout counter = 0.
- Reset mid-transaction: the transaction is abandoned and no m_ack/m_err is issued.
- Request sampled at edge N → s_cs high from cycle N+1.
- s_ack sampled high at edge K → m_ack high in cycle K+1 → IDLE at K+2.
- Zero-wait slave (ack in the first ACCESS cycle): m_ack is 2 cycles after the request edge.
- Minimum back-to-back period is 3 cycles, because IDLE lasts at least one cycle.
- All outputs are registered or derived from state only. There is no combinational path from m_* or s_ack to any output.

## Configuration
- BUS_TIMEOUT_EN defined:
  - The counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYC with s_ack[slave] = 0 in that cycle, go to RESP with m_err[idx] = 1, m_ack[idx] = 0 and m_rdata = 0.
  - If ack arrives in the same cycle as the timeout, ack wins.
- BUS_TIMEOUT_EN undefined:
  - No counter exists. ACCESS waits indefinitely.
  - m_err is tied to 0.

## Test plan
- Master 0 read: m_get=0001, m_req=0001, addr=0x4000_0010. Slave 1 acks on its 3rd ACCESS cycle with rdata=0x1234_5678 → s_cs=0010 for 3 cycles, then m_ack=0001 for one cycle with m_rdata=0x1234_5678.
- Master 2 write: addr=0xC000_0000, wdata=0xA5A5_A5A5, zero-wait ack from slave 3 → s_cs=1000, s_we=1, s_wdata=0xA5A5_A5A5 for one cycle; m_ack=0100 two cycles after the request edge.
- Grant moves from master 1 to master 3 during ACCESS → transaction completes; m_ack=0010 only, and master 3 starts no earlier than the following IDLE.
- m_get=0110 with both requesting → master 1 served first.
- With BUS_TIMEOUT_EN and TIMEOUT_CYC=16, slave never acks → m_err[idx] pulses after 16 ACCESS cycles, with m_rdata=0 and busy falling the next cycle. Repeat with ack on cycle 16 → m_ack, no m_err.
- rst asserted in ACCESS → next cycle s_cs=0, busy=0, no ack; a new request after release is served normally.
